// File: rtl/onehot_pkg.sv
// Shared types for the one-hot sequencer: command opcodes, output-stage states
// and rotation direction encoding.
package onehot_pkg;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'b00,
    OP_STEP_L  = 2'b01,
    OP_STEP_R  = 2'b10,
    OP_CLR_ERR = 2'b11
  } cmd_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Ops that always produce an output word when accepted (LOAD only when in range).
  function automatic logic op_is_step(input cmd_op_e op);
    return (op == OP_STEP_L) || (op == OP_STEP_R);
  endfunction

endpackage

// File: rtl/onehot_rotate.sv
// Combinational one-position rotate of a one-hot vector; wrap flags the bit
// that crossed the MSB/LSB boundary.
module onehot_rotate
  import onehot_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_vec,
  input  logic                  i_dir,
  output logic [DATA_WIDTH-1:0] o_vec,
  output logic                  o_wrap
);

  always_comb begin
    o_vec  = i_vec;
    o_wrap = 1'b0;
    if (i_dir == DIR_RIGHT) begin
      o_vec  = {i_vec[0], i_vec[DATA_WIDTH-1:1]};
      o_wrap = i_vec[0];
    end else begin
      o_vec  = {i_vec[DATA_WIDTH-2:0], i_vec[DATA_WIDTH-1]};
      o_wrap = i_vec[DATA_WIDTH-1];
    end
  end

endmodule

// File: rtl/onehot_sequencer.sv
// One-hot position sequencer with a single-entry valid/ready output stage and
// a sticky out-of-range error flag.
module onehot_sequencer
  import onehot_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [IDX_W-1:0]      cmd_idx,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_wrap,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  err
);

  localparam int unsigned DW = DATA_WIDTH;

  out_state_e            r_state;
  out_state_e            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pos;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_wrap;
  logic                  r_err;

  cmd_op_e               w_op;
  logic                  w_accept;
  logic                  w_take;
  logic                  w_idx_ok;
  logic                  w_dir;
  logic [DATA_WIDTH-1:0] w_load_vec;
  logic [DATA_WIDTH-1:0] w_rot;
  logic                  w_rot_wrap;
  logic                  w_produce;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_word_wrap;
  logic                  w_set_err;
  logic                  w_clr_err;

  assign w_op       = cmd_op_e'(cmd_op);
  assign cmd_ready  = (r_state == ST_EMPTY) | dout_ready;
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_take     = (r_state == ST_FULL) & dout_ready;
  assign w_idx_ok   = 32'(cmd_idx) < DW;
  assign w_load_vec = DATA_WIDTH'(1) << cmd_idx;
  assign w_dir      = (w_op == OP_STEP_R) ? DIR_RIGHT : DIR_LEFT;

  onehot_rotate #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rotate (
    .i_vec  (r_pos),
    .i_dir  (w_dir),
    .o_vec  (w_rot),
    .o_wrap (w_rot_wrap)
  );

  // Output-stage state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: a new word keeps the stage full even while the old one is taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_produce)            w_state_nxt = ST_FULL;
      ST_FULL:  if (w_take && !w_produce) w_state_nxt = ST_EMPTY;
      default:                            w_state_nxt = ST_EMPTY;
    endcase
  end

  // Command decode: what an accepted command does to pos, the word and err.
  always_comb begin
    w_produce   = 1'b0;
    w_word      = r_pos;
    w_word_wrap = 1'b0;
    w_set_err   = 1'b0;
    w_clr_err   = 1'b0;
    if (w_accept) begin
      case (w_op)
        OP_LOAD: begin
          if (w_idx_ok) begin
            w_produce = 1'b1;
            w_word    = w_load_vec;
          end else begin
            w_set_err = 1'b1;
          end
        end
        OP_STEP_L, OP_STEP_R: begin
          w_produce   = op_is_step(w_op);
          w_word      = w_rot;
          w_word_wrap = w_rot_wrap;
        end
        OP_CLR_ERR: w_clr_err = 1'b1;
        default:    w_clr_err = 1'b0;
      endcase
    end
  end

  // Datapath: pos and the output word advance together; a stalled word holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos  <= DATA_WIDTH'(1);
      r_dout <= '0;
      r_wrap <= 1'b0;
    end else if (w_produce) begin
      r_pos  <= w_word;
      r_dout <= w_word;
      r_wrap <= w_word_wrap;
    end
  end

  // Sticky error; clear takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_clr_err) begin
      r_err <= 1'b0;
    end else if (w_set_err) begin
      r_err <= 1'b1;
    end
  end

  assign dout       = r_dout;
  assign dout_wrap  = r_wrap;
  assign dout_valid = (r_state == ST_FULL);
  assign err        = r_err;

endmodule

// File: tb/tb_onehot_sequencer.sv
// Self-checking bench for onehot_sequencer (DATA_WIDTH=8, IDX_W=4): directed
// vector table, reset-during-valid sequence, and a random stream against a model.
module tb_onehot_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_idx;
  logic [7:0] dout;
  logic       dout_wrap;
  logic       dout_valid;
  logic       dout_ready;
  logic       err;

  onehot_sequencer #(
    .DATA_WIDTH (8),
    .IDX_W      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_idx    (cmd_idx),
    .dout       (dout),
    .dout_wrap  (dout_wrap),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       w;
  } word_t;

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [3:0] idx;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       ew;
    logic       ee;
    logic       er;
  } vec_t;

  word_t      sb[$];
  vec_t       tv[$];
  logic [7:0] m_pos;
  logic       m_err;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [1:0] op, input logic [3:0] idx,
                              input logic rdy, input logic ev, input logic [7:0] ed,
                              input logic ew, input logic ee, input logic er);
    vec_t t;
    t.v = v; t.op = op; t.idx = idx; t.rdy = rdy;
    t.ev = ev; t.ed = ed; t.ew = ew; t.ee = ee; t.er = er;
    return t;
  endfunction

  // Drive one cycle at the falling edge, check outputs against the scoreboard,
  // then advance the model as the DUT will on the coming rising edge.
  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] idx,
                       input logic rdy);
    logic  exp_rdy;
    logic  w;
    word_t e;
    @(negedge clk);
    cmd_valid  = v;
    cmd_op     = op;
    cmd_idx    = idx;
    dout_ready = rdy;
    #1;
    chk("dout_valid", 32'(dout_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("sb_dout", 32'(dout), 32'(sb[0].d));
      chk("sb_wrap", 32'(dout_wrap), 32'(sb[0].w));
    end
    chk("err", 32'(err), 32'(m_err));
    exp_rdy = (sb.size() == 0) || rdy;
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
    chk("pos_onehot", 32'($onehot(dut.r_pos)), 32'd1);
    chk("pos", 32'(dut.r_pos), 32'(m_pos));
    if ((sb.size() != 0) && rdy) void'(sb.pop_front());
    if (v && exp_rdy) begin
      case (op)
        2'b00: begin
          if (idx < 4'd8) begin
            m_pos = 8'd1 << idx;
            e.d = m_pos; e.w = 1'b0;
            sb.push_back(e);
          end else begin
            m_err = 1'b1;
          end
        end
        2'b01: begin
          w = m_pos[7];
          m_pos = {m_pos[6:0], m_pos[7]};
          e.d = m_pos; e.w = w;
          sb.push_back(e);
        end
        2'b10: begin
          w = m_pos[0];
          m_pos = {m_pos[0], m_pos[7:1]};
          e.d = m_pos; e.w = w;
          sb.push_back(e);
        end
        default: m_err = 1'b0;
      endcase
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_pos = 8'h01;
    m_err = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_idx    = 4'd0;
    dout_ready = 1'b0;
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_wrap", 32'(dout_wrap), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_pos", 32'(dut.r_pos), 32'h01);
    @(posedge clk);
    #1 reset = 1'b0;

    // v op idx rdy | expected at this row's sample: valid dout wrap err ready
    tv.push_back(mk(1, 2'd0, 4'd3, 1, 0, 8'h00, 0, 0, 1));
    tv.push_back(mk(1, 2'd0, 4'd7, 1, 1, 8'h08, 0, 0, 1));
    tv.push_back(mk(1, 2'd1, 4'd0, 1, 1, 8'h80, 0, 0, 1));
    tv.push_back(mk(1, 2'd2, 4'd0, 1, 1, 8'h01, 1, 0, 1));
    tv.push_back(mk(1, 2'd0, 4'd9, 1, 1, 8'h80, 1, 0, 1));
    tv.push_back(mk(0, 2'd0, 4'd0, 1, 0, 8'h00, 0, 1, 1));
    tv.push_back(mk(1, 2'd1, 4'd0, 1, 0, 8'h00, 0, 1, 1));
    tv.push_back(mk(1, 2'd3, 4'd0, 1, 1, 8'h01, 1, 1, 1));
    tv.push_back(mk(0, 2'd0, 4'd9, 1, 0, 8'h00, 0, 0, 1));
    tv.push_back(mk(1, 2'd0, 4'd0, 1, 0, 8'h00, 0, 0, 1));
    tv.push_back(mk(1, 2'd1, 4'd0, 0, 1, 8'h01, 0, 0, 0));
    tv.push_back(mk(1, 2'd0, 4'd5, 0, 1, 8'h01, 0, 0, 0));
    tv.push_back(mk(1, 2'd1, 4'd0, 0, 1, 8'h01, 0, 0, 0));
    tv.push_back(mk(1, 2'd1, 4'd0, 1, 1, 8'h01, 0, 0, 1));
    tv.push_back(mk(1, 2'd1, 4'd0, 1, 1, 8'h02, 0, 0, 1));
    tv.push_back(mk(1, 2'd1, 4'd0, 1, 1, 8'h04, 0, 0, 1));
    tv.push_back(mk(0, 2'd0, 4'd0, 1, 1, 8'h08, 0, 0, 1));
    tv.push_back(mk(0, 2'd0, 4'd0, 1, 0, 8'h00, 0, 0, 1));

    foreach (tv[i]) begin
      drive(tv[i].v, tv[i].op, tv[i].idx, tv[i].rdy);
      chk($sformatf("tv%0d_valid", i), 32'(dout_valid), 32'(tv[i].ev));
      if (tv[i].ev) begin
        chk($sformatf("tv%0d_dout", i), 32'(dout), 32'(tv[i].ed));
        chk($sformatf("tv%0d_wrap", i), 32'(dout_wrap), 32'(tv[i].ew));
      end
      chk($sformatf("tv%0d_err", i), 32'(err), 32'(tv[i].ee));
      chk($sformatf("tv%0d_ready", i), 32'(cmd_ready), 32'(tv[i].er));
    end

    // Reset while a word is stalled, with err set
    drive(1, 2'd0, 4'd12, 1);
    drive(1, 2'd0, 4'd2, 0);
    drive(0, 2'd0, 4'd0, 0);
    chk("pre_rst_valid", 32'(dout_valid), 32'd1);
    chk("pre_rst_err", 32'(err), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(dout_valid), 32'd0);
    chk("async_rst_dout", 32'(dout), 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
    chk("async_rst_ready", 32'(cmd_ready), 32'd1);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1, 2'd1, 4'd0, 1);
    drive(0, 2'd0, 4'd0, 1);
    chk("post_rst_step_dout", 32'(dout), 32'h02);
    chk("post_rst_step_wrap", 32'(dout_wrap), 32'd0);

    // Random command stream
    for (int n = 0; n < 10000; n++) begin
      drive(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 7));
    end
    drive(0, 2'd0, 4'd0, 1);
    drive(0, 2'd0, 4'd0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
